// File: rtl/break_recovery_ctrl.sv
// Break/recovery controller for the advanced-timer PWM output stage.
// Owns the main output enable (moe), qualifies fault removal and reports break entries.
module break_recovery_ctrl #(
  parameter int FLT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             pe_brk_clk,
  input  logic             pe_brk_rst,
  input  logic             fault_detected,
  input  logic             r_aoe,
  input  logic             r_moe_set,
  input  logic             r_moe_clr,
  input  logic             r_bif_clr,
  input  logic             r_cnt_clr,
  input  logic [FLT_W-1:0] r_flt_len,
  input  logic             update_event,
  output logic             moe,
  output logic             break_active,
  output logic             bif,
  output logic             break_irq,
  output logic             tim_dis,
  output logic [CNT_W-1:0] fault_cnt
);

  // state    | meaning
  // ST_OFF   | outputs disabled, waiting for software set or AOE update
  // ST_RUN   | outputs enabled (moe high unless fault present)
  // ST_BREAK | fault present, outputs forced off
  // ST_QUAL  | fault gone, counting fault-free cycles before allowing re-arm
  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_BREAK, ST_QUAL} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [FLT_W-1:0] r_qual_cnt;
  logic             r_bif;
  logic             r_irq;
  logic             r_tim_dis;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_entry;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_OFF: begin
        if (fault_detected)                          w_next = ST_BREAK;
        else if (r_moe_clr)                          w_next = ST_OFF;
        else if (r_moe_set || (r_aoe && update_event)) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (fault_detected) w_next = ST_BREAK;
        else if (r_moe_clr) w_next = ST_OFF;
      end
      ST_BREAK: begin
        if (!fault_detected) w_next = ST_QUAL;
      end
      ST_QUAL: begin
        if (fault_detected)         w_next = ST_BREAK;
        else if (r_qual_cnt == '0)  w_next = ST_OFF;
      end
      default: w_next = ST_OFF;
    endcase
  end

  // QUAL->BREAK belongs to the same episode, so only OFF/RUN count as entry.
  assign w_entry    = ((r_state == ST_OFF) || (r_state == ST_RUN)) && fault_detected;
  assign w_cnt_base = r_cnt_clr ? '0 : r_cnt;
  assign w_cnt_next = (w_entry && (w_cnt_base != '1)) ? w_cnt_base + CNT_W'(1) : w_cnt_base;

  always_ff @(posedge pe_brk_clk) begin
    if (pe_brk_rst) begin
      r_state    <= ST_OFF;
      r_qual_cnt <= '0;
      r_bif      <= 1'b0;
      r_irq      <= 1'b0;
      r_tim_dis  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_BREAK) && !fault_detected)
        r_qual_cnt <= r_flt_len;
      else if ((r_state == ST_QUAL) && !fault_detected && (r_qual_cnt != '0))
        r_qual_cnt <= r_qual_cnt - FLT_W'(1);
      r_irq     <= w_entry;
      r_tim_dis <= w_entry;
      if (w_entry)
        r_bif <= 1'b1;
      else if (r_bif_clr)
        r_bif <= 1'b0;
      r_cnt <= w_cnt_next;
    end
  end

  // Combinational fault gating gives same-cycle shutdown of the outputs.
  assign moe          = (r_state == ST_RUN) && !fault_detected;
  assign break_active = (r_state == ST_BREAK) || (r_state == ST_QUAL);
  assign bif          = r_bif;
  assign break_irq    = r_irq;
  assign tim_dis      = r_tim_dis;
  assign fault_cnt    = r_cnt;

endmodule

// File: tb/tb_break_recovery_ctrl.sv
// Self-checking bench for break_recovery_ctrl: per-scenario stimulus tables,
// expected observations queued on drive and popped at the following falling edge.
module tb_break_recovery_ctrl;

  typedef struct packed {
    logic rst, flt, set, clr, upd, bclr, cclr;
  } stim_t;

  typedef struct packed {
    logic       moe, ba, bif, irq, td;
    logic [3:0] cnt;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       fault;
  logic       aoe;
  logic       moe_set;
  logic       moe_clr;
  logic       bif_clr;
  logic       cnt_clr;
  logic [7:0] flt_len;
  logic       upd;
  logic       moe;
  logic       break_active;
  logic       bif;
  logic       break_irq;
  logic       tim_dis;
  logic [3:0] fault_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  break_recovery_ctrl #(.FLT_W(8), .CNT_W(4)) dut (
    .pe_brk_clk    (clk),
    .pe_brk_rst    (rst),
    .fault_detected(fault),
    .r_aoe         (aoe),
    .r_moe_set     (moe_set),
    .r_moe_clr     (moe_clr),
    .r_bif_clr     (bif_clr),
    .r_cnt_clr     (cnt_clr),
    .r_flt_len     (flt_len),
    .update_event  (upd),
    .moe           (moe),
    .break_active  (break_active),
    .bif           (bif),
    .break_irq     (break_irq),
    .tim_dis       (tim_dis),
    .fault_cnt     (fault_cnt)
  );

  function automatic stim_t S(logic f, logic st = 0, logic cl = 0, logic up = 0,
                              logic bc = 0, logic cc = 0, logic r = 0);
    S = '{rst: r, flt: f, set: st, clr: cl, upd: up, bclr: bc, cclr: cc};
  endfunction

  function automatic exp_t E(logic m, logic a, logic b, logic i, logic t, int c);
    E = '{moe: m, ba: a, bif: b, irq: i, td: t, cnt: 4'(c)};
  endfunction

  task automatic apply(input stim_t s);
    rst     = s.rst;
    fault   = s.flt;
    moe_set = s.set;
    moe_clr = s.clr;
    upd     = s.upd;
    bif_clr = s.bclr;
    cnt_clr = s.cclr;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e, got;
    rows.push_back('{S(0), E(0,0,0,0,0,0)});
    rows.push_back('{S(0), E(0,0,0,0,0,0)});
    foreach (rows[i]) begin
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      e   = sb.pop_front();
      got = {moe, break_active, bif, break_irq, tim_dis, fault_cnt};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset row=%0d got=%b expected=%b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_moe_fault();
    row_t rows[$];
    exp_t e, got;
    flt_len = 8'd3;
    aoe     = 1'b0;
    rows.push_back('{S(0,1),       E(0,0,0,0,0,0)});
    rows.push_back('{S(0,1),       E(1,0,0,0,0,0)});
    rows.push_back('{S(1),         E(0,0,0,0,0,0)});
    rows.push_back('{S(1),         E(0,1,1,1,1,1)});
    rows.push_back('{S(0),         E(0,1,1,0,0,1)});
    rows.push_back('{S(0),         E(0,1,1,0,0,1)});
    rows.push_back('{S(0,1),       E(0,1,1,0,0,1)});
    rows.push_back('{S(0,0,0,1),   E(0,1,1,0,0,1)});
    rows.push_back('{S(0),         E(0,1,1,0,0,1)});
    rows.push_back('{S(0),         E(0,0,1,0,0,1)});
    rows.push_back('{S(0),         E(0,0,1,0,0,1)});
    foreach (rows[i]) begin
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      e   = sb.pop_front();
      got = {moe, break_active, bif, break_irq, tim_dis, fault_cnt};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL moe_fault row=%0d got=%b expected=%b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_requal();
    row_t rows[$];
    exp_t e, got;
    flt_len = 8'd3;
    rows.push_back('{S(1), E(0,0,1,0,0,1)});
    rows.push_back('{S(0), E(0,1,1,1,1,2)});
    rows.push_back('{S(0), E(0,1,1,0,0,2)});
    rows.push_back('{S(1), E(0,1,1,0,0,2)});
    rows.push_back('{S(0), E(0,1,1,0,0,2)});
    for (int k = 0; k < 4; k++) rows.push_back('{S(0), E(0,1,1,0,0,2)});
    rows.push_back('{S(0), E(0,0,1,0,0,2)});
    foreach (rows[i]) begin
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      e   = sb.pop_front();
      got = {moe, break_active, bif, break_irq, tim_dis, fault_cnt};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL requal row=%0d got=%b expected=%b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_aoe();
    row_t rows[$];
    exp_t e, got;
    flt_len = 8'd0;
    aoe     = 1'b1;
    rows.push_back('{S(1),       E(0,0,1,0,0,2)});
    rows.push_back('{S(0,0,0,1), E(0,1,1,1,1,3)});
    rows.push_back('{S(0,0,0,1), E(0,1,1,0,0,3)});
    rows.push_back('{S(0),       E(0,0,1,0,0,3)});
    rows.push_back('{S(0,0,0,1), E(0,0,1,0,0,3)});
    rows.push_back('{S(0),       E(1,0,1,0,0,3)});
    rows.push_back('{S(0,0,1),   E(1,0,1,0,0,3)});
    rows.push_back('{S(0),       E(0,0,1,0,0,3)});
    foreach (rows[i]) begin
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      e   = sb.pop_front();
      got = {moe, break_active, bif, break_irq, tim_dis, fault_cnt};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL aoe row=%0d got=%b expected=%b", i, got, e);
      end
      @(posedge clk); #1;
    end
    aoe = 1'b0;
  endtask

  task automatic test_set_priority();
    row_t rows[$];
    exp_t e, got;
    flt_len = 8'd0;
    rows.push_back('{S(1,1),   E(0,0,1,0,0,3)});
    rows.push_back('{S(1,1),   E(0,1,1,1,1,4)});
    rows.push_back('{S(0),     E(0,1,1,0,0,4)});
    rows.push_back('{S(0),     E(0,1,1,0,0,4)});
    rows.push_back('{S(0,1,1), E(0,0,1,0,0,4)});
    rows.push_back('{S(0),     E(0,0,1,0,0,4)});
    rows.push_back('{S(0),     E(0,0,1,0,0,4)});
    foreach (rows[i]) begin
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      e   = sb.pop_front();
      got = {moe, break_active, bif, break_irq, tim_dis, fault_cnt};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL set_priority row=%0d got=%b expected=%b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cnt_sat();
    row_t rows[$];
    exp_t e, got;
    int   c;
    flt_len = 8'd0;
    rows.push_back('{S(0,0,0,0,0,1), E(0,0,1,0,0,4)});
    c = 0;
    for (int ep = 0; ep < 17; ep++) begin
      rows.push_back('{S(1), E(0,0,1,0,0,c)});
      c = (c == 15) ? 15 : c + 1;
      rows.push_back('{S(0), E(0,1,1,1,1,c)});
      rows.push_back('{S(0), E(0,1,1,0,0,c)});
    end
    rows.push_back('{S(0,0,0,0,1),   E(0,0,1,0,0,15)});
    rows.push_back('{S(1,0,0,0,1,1), E(0,0,0,0,0,15)});
    rows.push_back('{S(0),           E(0,1,1,1,1,1)});
    rows.push_back('{S(0),           E(0,1,1,0,0,1)});
    rows.push_back('{S(0),           E(0,0,1,0,0,1)});
    rows.push_back('{S(0,0,0,0,0,1), E(0,0,1,0,0,1)});
    rows.push_back('{S(0),           E(0,0,1,0,0,0)});
    foreach (rows[i]) begin
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      e   = sb.pop_front();
      got = {moe, break_active, bif, break_irq, tim_dis, fault_cnt};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL cnt_sat row=%0d got=%b expected=%b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_qual();
    row_t rows[$];
    exp_t e, got;
    flt_len = 8'd3;
    rows.push_back('{S(1),             E(0,0,1,0,0,0)});
    rows.push_back('{S(0),             E(0,1,1,1,1,1)});
    rows.push_back('{S(0),             E(0,1,1,0,0,1)});
    rows.push_back('{S(0,0,0,0,0,0,1), E(0,1,1,0,0,1)});
    rows.push_back('{S(0),             E(0,0,0,0,0,0)});
    rows.push_back('{S(0,1),           E(0,0,0,0,0,0)});
    rows.push_back('{S(0),             E(1,0,0,0,0,0)});
    foreach (rows[i]) begin
      apply(rows[i].s);
      sb.push_back(rows[i].e);
      @(negedge clk);
      e   = sb.pop_front();
      got = {moe, break_active, bif, break_irq, tim_dis, fault_cnt};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_in_qual row=%0d got=%b expected=%b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply(S(0,0,0,0,0,0,1));
    aoe     = 1'b0;
    flt_len = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_moe_fault();
    test_requal();
    test_aoe();
    test_set_priority();
    test_cnt_sat();
    test_reset_in_qual();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/break_recovery_ctrl.md
Name: break_recovery_ctrl

Overview:
- Consumer of the fault_detected level from the PE fault detection logic.
- Owns the main output enable (moe) of the advanced timer PWM stage.
- Forces outputs off on a fault and qualifies fault removal over a programmable number of cycles.
- Re-arms outputs by software set, or automatically on an update event (AOE). Also provides the sticky break flag, a break interrupt pulse, a timer-disable pulse and a saturating break counter.

Parameters:
FLT_W, 8, width of r_flt_len (fault-absent qualification length)
CNT_W, 4, width of fault_cnt (saturating break-entry counter)

Ports:
pe_brk_clk  input  1  block clock; all state changes on its rising edge
pe_brk_rst  input  1  synchronous, active-high reset
fault_detected  input  1  fault level from fault detection; high = fault present
r_aoe  input  1  automatic output enable: re-arm on update_event
r_moe_set  input  1  one-cycle software request to set moe
r_moe_clr  input  1  one-cycle software request to clear moe
r_bif_clr  input  1  one-cycle software clear of bif
r_cnt_clr  input  1  one-cycle clear of fault_cnt
r_flt_len  input  FLT_W  fault-absent cycles required before re-arm is allowed
update_event  input  1  one-cycle timer update event pulse
moe  output  1  main output enable to the PWM output stage
break_active  output  1  high while in BREAK or QUAL
bif  output  1  sticky break interrupt flag
break_irq  output  1  one-cycle pulse on break entry
tim_dis  output  1  one-cycle pulse on break entry; clears timer counter enable
fault_cnt  output  CNT_W  saturating count of break entries

Behaviour:
- Interface: one clock (pe_brk_clk); reset pe_brk_rst is synchronous and active-high.
- Reset: state = OFF, qual counter = 0, bif = 0, break_irq = 0, tim_dis = 0, fault_cnt = 0. Hence moe = 0 and break_active = 0.
- States: OFF, RUN, BREAK, QUAL. Encoding is free.
- moe = (state == RUN) && !fault_detected. This combinational path from fault_detected is deliberate and gives zero-cycle output shutdown.
- break_active = (state == BREAK) || (state == QUAL). Decoded from registered state only.
- OFF:
  - fault_detected -> BREAK.
  - else r_moe_clr -> stay OFF (clr wins over set).
  - else r_moe_set || (r_aoe && update_event) -> RUN.
- RUN:
  - fault_detected -> BREAK (wins over r_moe_clr).
  - else r_moe_clr -> OFF.
  - r_moe_set in RUN has no effect.
- BREAK:
  - fault_detected -> stay.
  - else -> QUAL, and load qual counter with r_flt_len.
- QUAL:
  - fault_detected -> BREAK.
  - else if qual counter == 0 -> OFF.
  - else decrement qual counter.
  - Dwell in QUAL is r_flt_len+1 cycles; r_flt_len = 0 gives 1 cycle.
- In BREAK and QUAL, r_moe_set and update_event are ignored and not remembered. After QUAL, outputs stay off until a fresh set or AOE update_event arrives in OFF.
- r_flt_len is sampled only when the qual counter is loaded; changes during QUAL have no effect until the next load.
- Break entry = transition OFF->BREAK or RUN->BREAK. QUAL->BREAK is the same episode: no irq, no tim_dis, no count.
- On break entry (registered, asserted the cycle after the fault is sampled):
  - break_irq = 1 for exactly one cycle.
  - tim_dis = 1 for exactly one cycle.
  - bif set.
  - fault_cnt increments, saturating at 2^CNT_W-1.
- bif: set on break entry; cleared by r_bif_clr. Set wins when both occur in the same cycle.
- fault_cnt: cleared by r_cnt_clr. Increment wins over clear in the same cycle (result = 1).
- Reset during any state returns to OFF on the same edge; no irq pulse is generated by reset.

Test Plan:
- Reset, then r_moe_set pulse -> moe = 1 from next cycle. Raise fault_detected -> moe = 0 the same cycle; next cycle break_irq = 1, tim_dis = 1, bif = 1, fault_cnt = 1, break_active = 1.
- r_flt_len = 3; drop fault in BREAK -> QUAL for 4 cycles, then OFF, moe stays 0. Re-raise fault at QUAL cycle 2 -> back to BREAK, no second irq, fault_cnt unchanged.
- r_aoe = 1; after QUAL expires, update_event pulse -> RUN, moe = 1. update_event issued during QUAL -> ignored, remains OFF after QUAL.
- In OFF, r_moe_set with fault_detected high in the same cycle -> BREAK, moe never 1. r_moe_set with r_moe_clr together -> stays OFF.
- CNT_W = 4, 17 break episodes -> fault_cnt = 15. r_cnt_clr -> 0. r_cnt_clr with entry in the same cycle -> 1. r_bif_clr with entry in the same cycle -> bif = 1.
- Assert pe_brk_rst during QUAL with fault low -> next cycle OFF, bif = 0, fault_cnt = 0, break_irq = 0, moe = 0.
